regfile_writeback: RTL and testbench

Write-port arbiter and pending-destination scoreboard placed in front of the core's 32x32 register file. Merges two result sources into the register file's single write port (`wen`/`wa`/`wd`):
- the in-order pipeline WB stage, which cannot stall;
- a long-latency result source (divider, load-miss unit) with a valid/ready handshake, buffered in a small FIFO.

A scoreboard tracks outstanding long-latency destinations so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_writeback_pkg.sv | 26 ++
 rtl/wb_result_fifo.sv | 46 ++++
 rtl/regfile_writeback.sv | 131 +++++++++++++
 tb/tb_regfile_writeback.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared widths, defaults and types for the register-file write-back slice.
package regfile_writeback_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int XLEN          = 32;
    localparam int NUM_REGS      = 32;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_STARVE_MAX = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] idx);
        onehot_reg      = '0;
        onehot_reg[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering long-latency results; head is combinational.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clock) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter merging the WB stage and buffered long-latency results,
// with a pending-destination scoreboard enabled by RISCY_WB_SCOREBOARD_EN.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH      = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  lng_valid,
    output logic                  lng_ready,
    input  logic [REG_ADDR_W-1:0] lng_rd,
    input  logic [XLEN-1:0]       lng_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] q_rsA,
    input  logic [REG_ADDR_W-1:0] q_rsB,
    input  logic [REG_ADDR_W-1:0] q_rd,
    output logic                  stall_o,
    output logic                  hold_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [XLEN-1:0]       wd
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    wb_entry_t     w_push_entry;
    wb_entry_t     w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_blocked;
    wb_src_e       w_src;
    logic [CW-1:0] r_starve;
    logic          r_hold;

    // Ready depends only on registered pointers, never on this cycle's pop.
    assign lng_ready    = !w_full && !reset;
    assign w_push_entry = '{rd: lng_rd, data: lng_data};

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (lng_valid && lng_ready),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_src = SRC_NONE;
        wen   = 1'b0;
        wa    = '0;
        wd    = '0;
        if (!r_hold && pipe_valid) begin
            w_src = SRC_PIPE;
            wen   = 1'b1;
            wa    = pipe_rd;
            wd    = pipe_data;
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
            wen   = 1'b1;
            wa    = w_head.rd;
            wd    = w_head.data;
        end
    end

    assign w_pop     = (w_src == SRC_FIFO);
    assign w_blocked = (w_src == SRC_PIPE) && !w_empty;
    assign hold_o    = r_hold;

    // The hold pulse is raised on the edge where the count reaches STARVE_MAX;
    // the pop it forces then clears the count, so the pulse lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_hold <= w_blocked && (r_starve == CW'(STARVE_MAX - 1));
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (w_blocked) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

`ifdef RISCY_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [2:0]          w_hit;

    assign w_set = (iss_valid && (iss_rd != '0)) ? onehot_reg(iss_rd) : '0;
    assign w_clr = w_pop ? onehot_reg(w_head.rd) : '0;

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign w_hit[0] = r_busy[q_rsA] && (q_rsA != '0) && !(w_pop && (wa == q_rsA));
    assign w_hit[1] = r_busy[q_rsB] && (q_rsB != '0) && !(w_pop && (wa == q_rsB));
    assign w_hit[2] = r_busy[q_rd]  && (q_rd  != '0) && !(w_pop && (wa == q_rd));

    assign stall_o = |w_hit;
    assign busy_o  = r_busy;
`else
    logic w_unused_scoreboard;

    assign w_unused_scoreboard = ^{iss_valid, iss_rd, q_rsA, q_rsB, q_rd};
    assign stall_o = 1'b0;
    assign busy_o  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback; scoreboard expectations
// follow whether RISCY_WB_SCOREBOARD_EN is defined.
module tb_regfile_writeback;

`ifdef RISCY_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_rd;
    logic [31:0] lng_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rsA;
    logic [4:0]  q_rsB;
    logic [4:0]  q_rd;
    logic        stall_o;
    logic        hold_o;
    logic [31:0] busy_o;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;

    int checks = 0;
    int errors = 0;

    regfile_writeback dut (
        .clock      (clock),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .lng_valid  (lng_valid),
        .lng_ready  (lng_ready),
        .lng_rd     (lng_rd),
        .lng_data   (lng_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .q_rsA      (q_rsA),
        .q_rsB      (q_rsB),
        .q_rd       (q_rd),
        .stall_o    (stall_o),
        .hold_o     (hold_o),
        .busy_o     (busy_o),
        .wen        (wen),
        .wa         (wa),
        .wd         (wd)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        lng_valid = 1'b0; lng_rd = '0; lng_data = '0;
        iss_valid = 1'b0; iss_rd = '0; q_rsA = '0; q_rsB = '0; q_rd = '0;

        // Reset state
        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("rst_ready", 32'(lng_ready), 32'd0);
        checkOutput("rst_wen", 32'(wen), 32'd0);
        checkOutput("rst_hold", 32'(hold_o), 32'd0);
        checkOutput("rst_busy", busy_o, 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        applyStimulus();
        reset = 1'b0;
        settle();
        checkOutput("rel_ready", 32'(lng_ready), 32'd1);

        // Pipe-only write, zero latency
        applyStimulus();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        settle();
        checkOutput("pipe_wen", 32'(wen), 32'd1);
        checkOutput("pipe_wa", 32'(wa), 32'd5);
        checkOutput("pipe_wd", wd, 32'hDEADBEEF);
        checkOutput("pipe_ready", 32'(lng_ready), 32'd1);

        // Long write to x7 with the pipe idle
        applyStimulus();
        pipe_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;
        settle();
        checkOutput("idle_wen", 32'(wen), 32'd0);
        checkOutput("idle_wa", 32'(wa), 32'd0);
        checkOutput("pre_issue_busy", busy_o, 32'd0);
        applyStimulus();
        iss_valid = 1'b0; q_rsA = 5'd7;
        lng_valid = 1'b1; lng_rd = 5'd7; lng_data = 32'h1234;
        settle();
        checkOutput("busy7_set", busy_o, SB ? 32'h80 : 32'h0);
        checkOutput("stall_rsA7", 32'(stall_o), 32'(SB));
        checkOutput("accept_no_write", 32'(wen), 32'd0);
        q_rsA = 5'd0;
        settle();
        checkOutput("stall_rsA0", 32'(stall_o), 32'd0);
        applyStimulus();
        lng_valid = 1'b0; q_rsA = 5'd7;
        settle();
        checkOutput("lng_wen", 32'(wen), 32'd1);
        checkOutput("lng_wa", 32'(wa), 32'd7);
        checkOutput("lng_wd", wd, 32'h1234);
        checkOutput("stall_bypass", 32'(stall_o), 32'd0);
        checkOutput("busy7_still", busy_o, SB ? 32'h80 : 32'h0);
        applyStimulus();
        settle();
        checkOutput("busy7_clear", busy_o, 32'd0);
        checkOutput("stall_after_clear", 32'(stall_o), 32'd0);
        checkOutput("drained_wen", 32'(wen), 32'd0);

        // Same-cycle set and clear of x9: set wins
        applyStimulus();
        q_rsA = 5'd0; iss_valid = 1'b1; iss_rd = 5'd9;
        settle();
        applyStimulus();
        iss_valid = 1'b0; lng_valid = 1'b1; lng_rd = 5'd9; lng_data = 32'hAA;
        settle();
        checkOutput("busy9_set", busy_o, SB ? 32'h200 : 32'h0);
        applyStimulus();
        lng_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9; q_rd = 5'd9;
        settle();
        checkOutput("x9_wa", 32'(wa), 32'd9);
        checkOutput("x9_wd", wd, 32'hAA);
        checkOutput("x9_bypass", 32'(stall_o), 32'd0);
        applyStimulus();
        iss_valid = 1'b0; lng_valid = 1'b1; lng_rd = 5'd9; lng_data = 32'hBB;
        settle();
        checkOutput("set_wins", busy_o, SB ? 32'h200 : 32'h0);
        checkOutput("stall_rd9", 32'(stall_o), 32'(SB));
        applyStimulus();
        lng_valid = 1'b0;
        settle();
        checkOutput("x9b_wd", wd, 32'hBB);
        applyStimulus();
        q_rd = 5'd0;
        settle();
        checkOutput("busy9_clear", busy_o, 32'd0);

        // Fill the FIFO while the pipe writes every cycle
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'(k);
            lng_valid = 1'b1; lng_rd = 5'(10 + k); lng_data = 32'h100 + 32'(k);
            settle();
            checkOutput("fill_ready", 32'(lng_ready), 32'd1);
            checkOutput("fill_wa", 32'(wa), 32'd1);
            checkOutput("fill_wd", wd, 32'(k));
            checkOutput("fill_hold", 32'(hold_o), 32'd0);
        end
        applyStimulus();
        lng_valid = 1'b0;
        settle();
        checkOutput("full_ready", 32'(lng_ready), 32'd0);
        checkOutput("full_hold", 32'(hold_o), 32'd0);
        for (int j = 0; j < 4; j++) begin
            applyStimulus();
            settle();
            checkOutput("starve1_hold", 32'(hold_o), 32'd0);
            checkOutput("starve1_wa", 32'(wa), 32'd1);
        end
        applyStimulus();
        settle();
        checkOutput("hold1", 32'(hold_o), 32'd1);
        checkOutput("hold1_wen", 32'(wen), 32'd1);
        checkOutput("hold1_wa", 32'(wa), 32'd10);
        checkOutput("hold1_wd", wd, 32'h100);
        checkOutput("hold1_ready", 32'(lng_ready), 32'd0);
        applyStimulus();
        settle();
        checkOutput("post_hold", 32'(hold_o), 32'd0);
        checkOutput("post_hold_ready", 32'(lng_ready), 32'd1);
        checkOutput("post_hold_wa", 32'(wa), 32'd1);
        for (int j = 0; j < 7; j++) begin
            applyStimulus();
            settle();
            checkOutput("starve2_hold", 32'(hold_o), 32'd0);
            checkOutput("starve2_wa", 32'(wa), 32'd1);
        end
        applyStimulus();
        settle();
        checkOutput("hold2", 32'(hold_o), 32'd1);
        checkOutput("hold2_wa", 32'(wa), 32'd11);
        checkOutput("hold2_wd", wd, 32'h101);

        // Reset with three FIFO entries and two busy bits
        applyStimulus();
        lng_valid = 1'b1; lng_rd = 5'd14; lng_data = 32'h104;
        iss_valid = 1'b1; iss_rd = 5'd20;
        settle();
        checkOutput("pre_rst_ready", 32'(lng_ready), 32'd1);
        checkOutput("pre_rst_hold", 32'(hold_o), 32'd0);
        applyStimulus();
        lng_valid = 1'b0; iss_rd = 5'd21;
        settle();
        checkOutput("busy20", busy_o, SB ? 32'h0010_0000 : 32'h0);
        applyStimulus();
        iss_valid = 1'b0; pipe_valid = 1'b0; reset = 1'b1;
        settle();
        checkOutput("midrst_ready", 32'(lng_ready), 32'd0);
        checkOutput("busy20_21", busy_o, SB ? 32'h0030_0000 : 32'h0);
        applyStimulus();
        reset = 1'b0; q_rsA = 5'd20;
        settle();
        checkOutput("midrst_wen", 32'(wen), 32'd0);
        checkOutput("midrst_wa", 32'(wa), 32'd0);
        checkOutput("midrst_wd", wd, 32'd0);
        checkOutput("midrst_busy", busy_o, 32'd0);
        checkOutput("midrst_hold", 32'(hold_o), 32'd0);
        checkOutput("midrst_stall", 32'(stall_o), 32'd0);
        checkOutput("midrst_ready_after", 32'(lng_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
